// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the
// direct-mapped write-through data cache controller.
package cache_pkg;

  localparam int ADDR_WIDTH     = 10;
  localparam int WORD_WIDTH     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE;
  localparam int INDEX_WIDTH    = 5;
  localparam int OFFSET_WIDTH   = 2;
  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    REFILL = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Word address layout is {tag, index, offset}, offset in the LSBs.
  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFSET_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/line_fill_buffer.sv
// Collects the words of a cache line arriving one per memory beat and
// presents them as a flat line, word k at bits [32k+31:32k].
module line_fill_buffer
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic [OFFSET_WIDTH-1:0] beat_o,
  output logic [LINE_WIDTH-1:0]   line_o
);

  logic [WORD_WIDTH-1:0]   words_q [WORDS_PER_LINE];
  logic [WORD_WIDTH-1:0]   words_d [WORDS_PER_LINE];
  logic [OFFSET_WIDTH-1:0] beat_q, beat_d;

  // The beat counter wraps naturally on the last load, which coincides with
  // the hand-off to the refill cycle.
  always_comb begin
    beat_d  = beat_q;
    words_d = words_q;
    if (clear_i) begin
      beat_d = '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        words_d[k] = '0;
      end
    end else if (load_i) begin
      words_d[beat_q] = data_i;
      beat_d          = beat_q + OFFSET_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        words_q[k] <= '0;
      end
    end else begin
      beat_q <= beat_d;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        words_q[k] <= words_d[k];
      end
    end
  end

  always_comb begin
    line_o = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      line_o[k*WORD_WIDTH +: WORD_WIDTH] = words_q[k];
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate controller for a direct-mapped cache:
// stalls the CPU on read misses (line fetch + refill) and on every store.
module cache_controller
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [WORD_WIDTH-1:0]   cpu_wdata,
  output logic                    stall,
  input  logic                    hit,
  output logic                    refill,
  output logic                    update,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [LINE_WIDTH-1:0]   line_data,
  output logic [WORD_WIDTH-1:0]   write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WORD_WIDTH-1:0]   mem_wdata,
  input  logic [WORD_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   laddr_q, laddr_d;
  logic [WORD_WIDTH-1:0]   lwdata_q, lwdata_d;
  logic                    buf_clear;
  logic                    buf_load;
  logic [OFFSET_WIDTH-1:0] beat;

  line_fill_buffer u_line_fill_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (buf_clear),
    .load_i  (buf_load),
    .data_i  (mem_rdata),
    .beat_o  (beat),
    .line_o  (line_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      laddr_q  <= '0;
      lwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      laddr_q  <= laddr_d;
      lwdata_q <= lwdata_d;
    end
  end

  // Stores win over loads; a store hit updates the array in the same cycle
  // it is seen and never again while the request is held.
  always_comb begin
    state_d   = state_q;
    laddr_d   = laddr_q;
    lwdata_d  = lwdata_q;
    stall     = 1'b1;
    refill    = 1'b0;
    update    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = laddr_q;
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    case (state_q)
      IDLE: begin
        stall = cpu_write | (cpu_read & ~hit);
        if (cpu_write) begin
          update   = hit;
          laddr_d  = cpu_addr;
          lwdata_d = cpu_wdata;
          state_d  = WRITE;
        end else if (cpu_read && !hit) begin
          laddr_d   = cpu_addr;
          buf_clear = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {addr_tag(laddr_q), addr_index(laddr_q), beat};
        if (mem_ready) begin
          buf_load = 1'b1;
          if (beat == OFFSET_WIDTH'(WORDS_PER_LINE - 1)) begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        refill  = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_q == IDLE) begin
      offset = addr_offset(cpu_addr);
      index  = addr_index(cpu_addr);
      tag    = addr_tag(cpu_addr);
    end else begin
      offset = addr_offset(laddr_q);
      index  = addr_index(laddr_q);
      tag    = addr_tag(laddr_q);
    end
  end

  assign write_data = cpu_wdata;
  assign mem_wdata  = lwdata_q;

endmodule
